// File: rtl/seg_scan_pwm.sv
// Four-digit multiplexed seven-segment scanner with PWM dimming.
// Ports: CLK100MHZ, Reset (async, high), BCD3..BCD0 digit values,
//   PWM duty; SegmentDrivers active-low anodes, SevenSegment
//   active-low cathodes {DP,g,f,e,d,c,b,a}.
module seg_scan_pwm #(
  parameter int SCAN_BITS = 17,
  parameter int GUARD     = 16
) (
  input  logic       CLK100MHZ,
  input  logic       Reset,
  input  logic [3:0] BCD3,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD0,
  input  logic [7:0] PWM,
  output logic [7:0] SegmentDrivers,
  output logic [7:0] SevenSegment
);

  localparam logic [SCAN_BITS-1:0] GUARD_C =
    SCAN_BITS'(GUARD);

  logic [SCAN_BITS-1:0] scnt;
  logic [1:0]           idx;
  logic [7:0]           pcnt;
  logic [7:0]           pwm_lat;
  logic [3:0]           fb [4];

  logic       slot_start;
  logic       slot_end;
  logic       lit;
  logic [3:0] digit;
  logic [7:0] dec;
  logic [7:0] drv_nxt;
  logic [7:0] seg_nxt;

  assign slot_start = (scnt == '0);
  assign slot_end   = &scnt;

  // Output for this edge is built from the state
  // before the edge; slot 0..GUARD-1 is blanked so
  // freshly latched values never reach a lit digit.
  always_comb begin
    digit = fb[idx];
    lit   = (scnt >= GUARD_C) && (pcnt < pwm_lat);
    case (digit)
      4'd0:    dec = 8'hC0;
      4'd1:    dec = 8'hF9;
      4'd2:    dec = 8'hA4;
      4'd3:    dec = 8'hB0;
      4'd4:    dec = 8'h99;
      4'd5:    dec = 8'h92;
      4'd6:    dec = 8'h82;
      4'd7:    dec = 8'hF8;
      4'd8:    dec = 8'h80;
      4'd9:    dec = 8'h90;
      default: dec = 8'hFF;
    endcase
    drv_nxt = 8'hFF;
    seg_nxt = 8'hFF;
    if (lit) begin
      drv_nxt = ~(8'h01 << idx);
      seg_nxt = dec;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge Reset) begin
    if (Reset) begin
      scnt           <= '0;
      idx            <= '0;
      pcnt           <= '0;
      pwm_lat        <= '0;
      fb             <= '{default: '0};
      SegmentDrivers <= 8'hFF;
      SevenSegment   <= 8'hFF;
    end else begin
      scnt <= scnt + 1'b1;
      pcnt <= pcnt + 1'b1;
      if (slot_end)
        idx <= idx + 1'b1;
      if (slot_start)
        pwm_lat <= PWM;
      if (slot_start && idx == 2'd0) begin
        fb[0] <= BCD0;
        fb[1] <= BCD1;
        fb[2] <= BCD2;
        fb[3] <= BCD3;
      end
      SegmentDrivers <= drv_nxt;
      SevenSegment   <= seg_nxt;
    end
  end

endmodule
